// File: rtl/fifo_pkg.sv
// Shared types and constants for the sync_fifo read-side streaming path.
package fifo_pkg;
  typedef enum logic {ST_STREAM = 1'b0, ST_FLUSH = 1'b1} state_t;
  localparam int OBUF_DEPTH = 2;
endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order output buffer; entry 0 is always the head presented downstream.
module stream_skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            occ
);
  logic [DATA_WIDTH-1:0] ent0, ent1;
  logic                  do_push, do_pop;

  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != 2'(OBUF_DEPTH)) || do_pop);
  assign dout    = ent0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (clear) begin
      occ <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= din;
          else             ent1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        // simultaneous push/pop: shift the tail forward, new beat lands behind it
        2'b11: begin
          if (occ == 2'd1) ent0 <= din;
          else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Drains a 1-cycle-latency sync_fifo read port into a framed valid/ready stream with flush.
module sync_fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_W      = $clog2(PKT_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic                  busy,
  output logic [CNT_W-1:0]      beat_idx
);
  state_t      state, state_nxt;
  logic        inflight;
  logic [1:0]  occ;
  logic [2:0]  fill;
  logic        xfer, flush_go, pop, push, clear;

  assign xfer     = m_valid && m_ready;
  assign flush_go = flush && (state == ST_STREAM);
  assign pop      = xfer && !flush_go;
  assign push     = inflight && (state == ST_STREAM) && !flush_go;
  assign clear    = flush_go || (state == ST_FLUSH);
  // buffered + in flight after this cycle's pop; never negative because m_valid implies occ>=1
  assign fill     = {1'b0, occ} + {2'b0, inflight} - {2'b0, xfer};

  assign m_valid  = (occ != 2'd0);
  assign m_last   = m_valid && (beat_idx == CNT_W'(PKT_LEN - 1));

  stream_skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (fifo_rd_data),
    .dout  (m_data),
    .occ   (occ)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_STREAM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STREAM: if (flush) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (fifo_empty && !inflight) state_nxt = ST_STREAM;
      default:   state_nxt = ST_STREAM;
    endcase
  end

  // reads are held off during reset since inflight is cleared and the data would be lost
  always_comb begin
    fifo_rd_en = 1'b0;
    busy       = 1'b0;
    if (rst_n) begin
      case (state)
        ST_STREAM: fifo_rd_en = !fifo_empty && (fill < 3'd2);
        ST_FLUSH: begin
          fifo_rd_en = !fifo_empty;
          busy       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      beat_idx <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (clear)
        beat_idx <= '0;
      else if (pop)
        beat_idx <= (beat_idx == CNT_W'(PKT_LEN - 1)) ? '0 : beat_idx + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench: queue-based sync_fifo (DEPTH 16) feeding the reader, plus a stream scoreboard.
module tb_sync_fifo_stream_reader;
  localparam int DW = 8;
  localparam int PL = 4;
  localparam int CW = $clog2(PL) + 1;
  localparam int FDEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          flush;
  logic          busy;
  logic [CW-1:0] beat_idx;
  logic          wr_en;
  logic [DW-1:0] wr_data;

  int tests = 0, errs = 0, cyc = 0, beats = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] xd_log[$];
  logic          xl_log[$];
  int            xc_log[$], rd_log[$], val_log[$];

  sync_fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .flush(flush), .busy(busy), .beat_idx(beat_idx)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    xd_log.delete(); xl_log.delete(); xc_log.delete(); rd_log.delete(); val_log.delete();
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || m_valid) && n < bound) begin
      step(); n++;
    end
    chk("drain_in_time", 32'(n < bound), 1);
  endtask

  // sync_fifo model: registered empty flag, read data one cycle after rd_en
  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (wr_en && fq.size() < FDEPTH) fq.push_back(wr_data);
    end
    fifo_empty <= (fq.size() == 0);
  end

  // stream expectation: every written value comes out in order unless flushed or reset
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete(); beats = 0;
    end else begin
      if (flush) begin
        exp_q.delete(); beats = 0;
      end else if (m_valid && m_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beats = (beats + 1) % PL;
      end
      if (wr_en) exp_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("no_read_while_empty", 32'(fifo_rd_en && fifo_empty), 0);
      if (busy) chk("valid_low_in_flush", 32'(m_valid), 0);
      else if (m_valid) begin
        if (exp_q.size() == 0) chk("valid_with_nothing_expected", 32'(m_valid), 0);
        else begin
          chk("m_data", 32'(m_data), 32'(exp_q[0]));
          chk("m_last", 32'(m_last), 32'(beats == PL - 1));
          chk("beat_idx", 32'(beat_idx), 32'(beats));
        end
      end
      if (fifo_rd_en) rd_log.push_back(cyc);
      if (m_valid) val_log.push_back(cyc);
      if (m_valid && m_ready) begin
        xd_log.push_back(m_data); xl_log.push_back(m_last); xc_log.push_back(cyc);
      end
    end
  end

  initial begin
    int n, sent;
    rst_n = 1'b0; m_ready = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_beat_idx", 32'(beat_idx), 0);
    step(); rst_n = 1'b1;

    // 1: back-to-back streaming
    clear_logs(); m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin wr_en = 1'b1; wr_data = 8'h10 + 8'(i); step(); end
    wr_en = 1'b0;
    wait_drain(40);
    chk("t1_count", 32'(xd_log.size()), 8);
    if (xd_log.size() == 8) begin
      chk("t1_first", 32'(xd_log[0]), 32'h10);
      chk("t1_last_data", 32'(xd_log[7]), 32'h17);
      chk("t1_last_on_13", 32'(xl_log[3]), 1);
      chk("t1_last_on_17", 32'(xl_log[7]), 1);
      chk("t1_nolast_on_10", 32'(xl_log[0]), 0);
      chk("t1_consecutive", 32'(xc_log[7] - xc_log[0]), 7);
    end

    // 2: downstream stall
    clear_logs(); m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin wr_en = 1'b1; wr_data = 8'h20 + 8'(i); step(); end
    wr_en = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("t2_fifo_count", 32'(fq.size()), 14);
    chk("t2_rd_en", 32'(fifo_rd_en), 0);
    chk("t2_valid", 32'(m_valid), 1);
    chk("t2_held", 32'(m_data), 32'h20);
    step(); m_ready = 1'b1;
    wait_drain(60);
    chk("t2_count", 32'(xd_log.size()), 16);
    if (xd_log.size() == 16) chk("t2_tail", 32'(xd_log[15]), 32'h2F);

    // 3: random producer and consumer
    clear_logs(); sent = 0; n = 0;
    while (xd_log.size() < 64 && n < 2000) begin
      wr_en = (sent < 64) && (fq.size() < FDEPTH - 1) && ($urandom_range(0, 3) != 0);
      wr_data = 8'($urandom);
      if (wr_en) sent++;
      m_ready = 1'($urandom_range(0, 1));
      step(); n++;
    end
    wr_en = 1'b0; m_ready = 1'b1;
    wait_drain(100);
    chk("t3_count", 32'(xd_log.size()), 64);
    for (int i = 0; i < xl_log.size(); i++) chk("t3_last_every_4th", 32'(xl_log[i]), 32'(i % 4 == 3));

    // 4: flush after partial packet
    clear_logs(); m_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin wr_en = 1'b1; wr_data = 8'h30 + 8'(i); step(); end
    wr_en = 1'b0;
    repeat (4) step();
    m_ready = 1'b1; step(); step();
    m_ready = 1'b0; flush = 1'b1; step(); flush = 1'b0;
    @(negedge clk);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_valid_dropped", 32'(m_valid), 0);
    chk("t4_two_sent", 32'(xd_log.size()), 2);
    n = 0;
    while (busy && n < 40) begin step(); n++; end
    chk("t4_flush_ends", 32'(busy), 0);
    @(negedge clk);
    chk("t4_beat_idx", 32'(beat_idx), 0);
    chk("t4_fifo_drained", 32'(fq.size()), 0);
    chk("t4_valid_after", 32'(m_valid), 0);
    step(); wr_en = 1'b1; wr_data = 8'hA5; step(); wr_en = 1'b0;
    n = 0;
    while (n < 10) begin @(negedge clk); if (m_valid) break; n++; end
    chk("t4_a5_valid", 32'(m_valid), 1);
    chk("t4_a5_data", 32'(m_data), 32'hA5);
    chk("t4_a5_beat", 32'(beat_idx), 0);
    step(); m_ready = 1'b1;
    wait_drain(20);

    // 5: reset mid-stream
    clear_logs(); m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin wr_en = 1'b1; wr_data = 8'h40 + 8'(i); step(); end
    wr_en = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rd_en_in_reset", 32'(fifo_rd_en), 0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("t5_valid", 32'(m_valid), 0);
    chk("t5_data", 32'(m_data), 0);
    chk("t5_last", 32'(m_last), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_beat", 32'(beat_idx), 0);
    chk("t5_rd_en", 32'(fifo_rd_en), 0);

    // 6: single beat latency
    step(); clear_logs(); m_ready = 1'b1;
    wr_en = 1'b1; wr_data = 8'h77; step(); wr_en = 1'b0;
    repeat (6) step();
    chk("t6_rd_count", 32'(rd_log.size()), 1);
    chk("t6_valid_count", 32'(val_log.size()), 1);
    if (rd_log.size() == 1 && val_log.size() == 1) begin
      chk("t6_latency", 32'(val_log[0] - rd_log[0]), 2);
      chk("t6_data", 32'(xd_log.size() > 0 ? xd_log[0] : 8'h00), 32'h77);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
